alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared, combinational ALU: grant, capture, execute, respond.
// Optional build macro ALU_ARB_ILLEGAL_OP_EN: opcodes above 18 return rsp_err=1 with rsp_data=0.
module alu_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_op,
    input  logic [31:0] req0_in1,
    input  logic [31:0] req0_in2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_op,
    input  logic [31:0] req1_in1,
    input  logic [31:0] req1_in2,
    output logic [4:0]  alu_op,
    output logic [31:0] alu_input1,
    output logic [31:0] alu_input2,
    output logic [18:0] alu_en,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [1:0]  dbg_state
);

    // Handshakes: a request transfers on the rising edge where valid && ready are both 1;
    // a response transfers on the rising edge where rsp_valid && rsp_ready are both 1.
    // ready depends combinationally on valid, so requesters must not wait for ready first.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        last_grant;
    logic        gnt_valid;
    logic        gnt_id;
    logic [4:0]  cap_op;
    logic [31:0] cap_in1;
    logic [31:0] cap_in2;
    logic        cap_id;
    logic        illegal;

    assign illegal    = (cap_op > 5'd18);
    assign alu_op     = cap_op;
    assign alu_input1 = cap_in1;
    assign alu_input2 = cap_in2;
    assign rsp_id     = cap_id;
    assign dbg_state  = state;

    always_comb begin
        state_next = state;
        gnt_valid  = 1'b0;
        gnt_id     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        alu_en     = '0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                // readys are gated by rst_n so nothing looks accepted while reset is held
                if (rst_n && (req0_valid || req1_valid)) begin
                    gnt_valid = 1'b1;
                    if (req0_valid && req1_valid)
                        gnt_id = (RR_EN != 0) ? ~last_grant : 1'b0;
                    else
                        gnt_id = req1_valid;
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (!illegal)
                    alu_en = 19'd1 << cap_op;
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cap_op     <= '0;
            cap_in1    <= '0;
            cap_in2    <= '0;
            cap_id     <= 1'b0;
            rsp_data   <= '0;
        end else begin
            state <= state_next;
            if (gnt_valid) begin
                last_grant <= gnt_id;
                cap_id     <= gnt_id;
                cap_op     <= gnt_id ? req1_op  : req0_op;
                cap_in1    <= gnt_id ? req1_in1 : req0_in1;
                cap_in2    <= gnt_id ? req1_in2 : req0_in2;
            end
            if (state == EXEC) begin
`ifdef ALU_ARB_ILLEGAL_OP_EN
                rsp_data <= illegal ? 32'd0 : alu_result;
`else
                rsp_data <= alu_result;
`endif
            end
        end
    end

`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (state == EXEC)
            err_q <= illegal;
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance and a fixed-priority instance
// share stimulus; an ALU model closes the loop on each instance's alu_* outputs.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_op, req1_op;
    logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic        rsp_ready;

    logic        req0_ready, req1_ready;
    logic [4:0]  alu_op;
    logic [31:0] alu_input1, alu_input2, alu_result;
    logic [18:0] alu_en;
    logic        rsp_valid, rsp_id, rsp_err;
    logic [31:0] rsp_data;
    logic [1:0]  dbg_state;

    logic        fp_req0_ready, fp_req1_ready;
    logic [4:0]  fp_alu_op;
    logic [31:0] fp_alu_input1, fp_alu_input2, fp_alu_result;
    logic [18:0] fp_alu_en;
    logic        fp_rsp_valid, fp_rsp_id, fp_rsp_err;
    logic [31:0] fp_rsp_data;
    logic [1:0]  fp_dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] exp_q[$];

    // Reference ALU: 0 ADD,1 ADDI,2 SUB,3 AND,4 ANDI,5 OR,6 ORI,7 XOR,8 XORI,9 SLL,10 SLLI,
    // 11 SRL,12 SRLI,13 SRA,14 SRAI,15 SLT,16 SLTI,17 SLTU,18 SLTIU; no enable gives 0.
    function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [18:0] en);
        if (en == 19'd0) return 32'd0;
        case (op)
            5'd0, 5'd1:   return a + b;
            5'd2:         return a - b;
            5'd3, 5'd4:   return a & b;
            5'd5, 5'd6:   return a | b;
            5'd7, 5'd8:   return a ^ b;
            5'd9, 5'd10:  return a << b[4:0];
            5'd11, 5'd12: return a >> b[4:0];
            5'd13, 5'd14: return $unsigned($signed(a) >>> b[4:0]);
            5'd15, 5'd16: return {31'd0, $signed(a) < $signed(b)};
            5'd17, 5'd18: return {31'd0, a < b};
            default:      return 32'd0;
        endcase
    endfunction

    assign alu_result    = alu_model(alu_op, alu_input1, alu_input2, alu_en);
    assign fp_alu_result = alu_model(fp_alu_op, fp_alu_input1, fp_alu_input2, fp_alu_en);

    alu_arbiter #(.RR_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_in1(req0_in1), .req0_in2(req0_in2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_in1(req1_in1), .req1_in2(req1_in2),
        .alu_op(alu_op), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_en(alu_en), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .dbg_state(dbg_state)
    );

    alu_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op),
        .req0_in1(req0_in1), .req0_in2(req0_in2),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op),
        .req1_in1(req1_in1), .req1_in2(req1_in2),
        .alu_op(fp_alu_op), .alu_input1(fp_alu_input1), .alu_input2(fp_alu_input2),
        .alu_en(fp_alu_en), .alu_result(fp_alu_result),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
        .rsp_data(fp_rsp_data), .rsp_err(fp_rsp_err), .dbg_state(fp_dbg_state)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input int port, input logic [4:0] op,
                             input logic [31:0] a, input logic [31:0] b);
        if (port == 0) begin
            req0_op = op; req0_in1 = a; req0_in2 = b; req0_valid = 1'b1;
        end else begin
            req1_op = op; req1_in1 = a; req1_in2 = b; req1_valid = 1'b1;
        end
    endtask

    // One complete transaction with a configurable number of RESP stall cycles.
    task automatic run_op(input string tag, input int port, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [18:0] exp_en,
                          input logic [31:0] exp_data, input logic exp_err, input int stall);
        int t;
        logic rdy;
        @(negedge clk);
        rsp_ready = 1'b0;
        drive_req(port, op, a, b);
        #1;
        t = 0;
        rdy = (port == 0) ? req0_ready : req1_ready;
        while (!rdy && t < 20) begin
            @(negedge clk); #1; t++;
            rdy = (port == 0) ? req0_ready : req1_ready;
        end
        check({tag, "_grant"}, 32'(rdy), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check({tag, "_alu_en"}, 32'(alu_en), 32'(exp_en));
        check({tag, "_alu_in1"}, alu_input1, a);
        t = 0;
        while (!rsp_valid && t < 20) begin
            @(negedge clk); #1; t++;
        end
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        if (stall > 0) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
        end
        for (int s = 0; s < stall; s++) begin
            check({tag, "_stall_rdy"}, 32'({req1_ready, req0_ready}), 32'd0);
            check({tag, "_stall_data"}, rsp_data, exp_data);
            check({tag, "_stall_id"}, 32'(rsp_id), 32'(port));
            @(negedge clk); #1;
        end
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'(port));
        check({tag, "_rsp_data"}, rsp_data, exp_data);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        check({tag, "_exit_state"}, 32'(dbg_state), 32'd0);
        check({tag, "_exit_valid"}, 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int stale;
        int both_rdy;
        int n_g, n_fg;
        int g_ord[8];
        int fg_ord[8];
        logic [32:0] e;

        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = '0; req1_op = '0;
        req0_in1 = '0; req0_in2 = '0; req1_in1 = '0; req1_in2 = '0;
        drive_req(0, 5'd0, 32'd5, 32'd7);
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_en", 32'(alu_en), 32'd0);
        check("rst_alu_in1", alu_input1, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_id_err", 32'({rsp_id, rsp_err}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        // ADD 5+7: accept on the first edge after release, respond two cycles later
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("add_first_grant", 32'({req1_ready, req0_ready}), 32'd1);
        @(negedge clk); #1;
        req0_valid = 1'b0;
        check("add_exec_en", 32'(alu_en), 32'h00001);
        check("add_exec_state", 32'(dbg_state), 32'd1);
        check("add_exec_nrsp", 32'(rsp_valid), 32'd0);
        @(negedge clk); #1;
        check("add_rsp_valid", 32'(rsp_valid), 32'd1);
        check("add_rsp_id", 32'(rsp_id), 32'd0);
        check("add_rsp_data", rsp_data, 32'd12);
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        check("add_exit", 32'(dbg_state), 32'd0);
        rsp_ready = 1'b0;

        run_op("sra", 1, 5'd13, 32'h8000_0000, 32'd4, 19'h02000, 32'hF800_0000, 1'b0, 0);
        run_op("sltu", 0, 5'd17, 32'hFFFF_FFFF, 32'd1, 19'h20000, 32'd0, 1'b0, 0);
        run_op("slt", 1, 5'd15, 32'hFFFF_FFFF, 32'd1, 19'h08000, 32'd1, 1'b0, 0);
        run_op("sub_stall", 0, 5'd2, 32'd10, 32'd3, 19'h00004, 32'd7, 1'b0, 4);
        run_op("xor", 1, 5'd7, 32'h0000_F0F0, 32'h0000_0FF0, 19'h00080, 32'h0000_FF00, 1'b0, 0);
`ifdef ALU_ARB_ILLEGAL_OP_EN
        run_op("illegal", 0, 5'b10101, 32'd9, 32'd9, 19'h0, 32'd0, 1'b1, 0);
`else
        run_op("illegal", 0, 5'b10101, 32'd9, 32'd9, 19'h0, 32'd0, 1'b0, 0);
`endif
        run_op("add_after_ill", 0, 5'd0, 32'd1, 32'd1, 19'h00001, 32'd2, 1'b0, 0);

        // reset pulsed while in EXEC
        @(negedge clk);
        drive_req(0, 5'd0, 32'd3, 32'd4);
        @(negedge clk); #1;
        req0_valid = 1'b0;
        check("mid_rst_in_exec", 32'(dbg_state), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        check("mid_rst_alu_en", 32'(alu_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (rsp_valid) stale++;
            @(negedge clk);
        end
        check("mid_rst_stale", 32'(stale), 32'd0);
        run_op("add_after_rst", 0, 5'd0, 32'd3, 32'd4, 19'h00001, 32'd7, 1'b0, 0);

        // contention from a fresh reset: RR alternates from port 0, fixed priority stays on 0
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        drive_req(0, 5'd0, 32'd1, 32'd2);
        drive_req(1, 5'd0, 32'd10, 32'd20);
        both_rdy = 0; n_g = 0; n_fg = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (req0_ready && req1_ready) both_rdy++;
            if ((req0_ready || req1_ready) && n_g < 8) begin
                g_ord[n_g] = req1_ready ? 1 : 0;
                exp_q.push_back(req1_ready ? {1'b1, 32'd30} : {1'b0, 32'd3});
                n_g++;
            end
            if ((fp_req0_ready || fp_req1_ready) && n_fg < 8) begin
                fg_ord[n_fg] = fp_req1_ready ? 1 : 0;
                n_fg++;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rr_rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rr_rsp_id", 32'(rsp_id), 32'(e[32]));
                    check("rr_rsp_data", rsp_data, e[31:0]);
                end
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr_both_ready", 32'(both_rdy), 32'd0);
        check("rr_grant_count", 32'(n_g), 32'd4);
        check("fp_grant_count", 32'(n_fg), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_order_%0d", k), 32'(g_ord[k]), 32'(k % 2));
            check($sformatf("fp_order_%0d", k), 32'(fg_ord[k]), 32'd0);
        end
        check("rr_queue_empty", 32'(exp_q.size()), 32'd0);
        rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
